// File: rtl/dataset_ram.sv
// Row-per-point dataset store: masked lane writes, random reads and a burst stream port.
// Latency: random read and first stream beat 1 cycle; writes commit at the sampling edge.
// Backpressure: stream beats hold while rvalid && !rready; clear sweep ignores commands.
module dataset_ram #(
    parameter int ADDR_WIDTH   = 12,
    parameter int MAX_FEATURES = 15,
    parameter int LENGTH       = 16,
    parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1),
    parameter int DEPTH        = 100
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    clr_req,
    input  logic                    we,
    input  logic [MAX_FEATURES:0]   wmask,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    input  logic                    strm_start,
    input  logic [ADDR_WIDTH-1:0]   strm_base,
    input  logic [ADDR_WIDTH:0]     strm_len,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    output logic                    strm_last,
    output logic                    busy,
    output logic                    err
);

    localparam int LANES = MAX_FEATURES + 1;
    // Index width just wide enough for DEPTH rows; addresses are range-checked before slicing.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH + 1)'(1);
    localparam logic [IW-1:0]       LAST_ROW = IW'(DEPTH - 1);

    typedef enum logic [1:0] {CLEAR, IDLE, STREAM} state_t;

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [IW-1:0]           clr_ptr;
    logic [ADDR_WIDTH-1:0]   ptr;     // row currently presented on the stream port
    logic [ADDR_WIDTH:0]     end_r;   // one past the final burst row

    logic                    waddr_ok, raddr_ok, start_ok;
    logic [ADDR_WIDTH:0]     strm_end, nxt;
    logic                    xfer, wr_go, rd_go, st_go, fetch, err_c;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [IW-1:0]           wr_idx, rd_idx, mem_idx;
    logic [DATA_WIDTH-1:0]   wr_row, rd_fwd, mem_wdat;
    logic                    mem_we;

    function automatic logic [DATA_WIDTH-1:0] merge_row(input logic [DATA_WIDTH-1:0] old_row,
                                                        input logic [DATA_WIDTH-1:0] nw_row,
                                                        input logic [LANES-1:0]      mask);
        logic [DATA_WIDTH-1:0] r;
        r = old_row;
        for (int k = 0; k < LANES; k++) begin
            if (mask[k]) r[k*LENGTH +: LENGTH] = nw_row[k*LENGTH +: LENGTH];
        end
        return r;
    endfunction

    // Length is bounded first so the end sum cannot overflow ADDR_WIDTH+1 bits.
    assign waddr_ok = {1'b0, waddr} < DEPTH_W;
    assign raddr_ok = {1'b0, raddr} < DEPTH_W;
    assign strm_end = {1'b0, strm_base} + strm_len;
    assign start_ok = (strm_len != '0) && (strm_len <= DEPTH_W) && (strm_end <= DEPTH_W);
    assign nxt      = {1'b0, ptr} + ONE_W;
    assign xfer     = rvalid && rready;
    assign busy     = (state != IDLE);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= CLEAR;
        else     state <= state_nxt;
    end

    // Next state, command arbitration and error detection.
    always_comb begin
        state_nxt = state;
        err_c     = 1'b0;
        wr_go     = 1'b0;
        rd_go     = 1'b0;
        st_go     = 1'b0;
        fetch     = 1'b0;
        case (state)
            CLEAR: begin
                if (clr_ptr == LAST_ROW) state_nxt = IDLE;
            end
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    err_c     = strm_start || re;
                end else begin
                    wr_go = we && waddr_ok;
                    if (we && !waddr_ok) err_c = 1'b1;
                    if (strm_start) begin
                        if (start_ok) begin
                            st_go     = 1'b1;
                            state_nxt = STREAM;
                        end else begin
                            err_c = 1'b1;
                        end
                        if (re) err_c = 1'b1;
                    end else if (re) begin
                        if (raddr_ok) rd_go = 1'b1;
                        else          err_c = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (re || strm_start) err_c = 1'b1;
                if (clr_req) begin
                    state_nxt = CLEAR;
                end else begin
                    wr_go = we && waddr_ok;
                    if (we && !waddr_ok) err_c = 1'b1;
                    if (xfer && strm_last) state_nxt = IDLE;
                    else if (xfer)         fetch     = 1'b1;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // Read/write port addressing with write-first forwarding of the merged row.
    always_comb begin
        rd_addr  = ptr;
        if (st_go)      rd_addr = strm_base;
        else if (rd_go) rd_addr = raddr;
        else if (fetch) rd_addr = nxt[ADDR_WIDTH-1:0];
        wr_idx   = waddr[IW-1:0];
        rd_idx   = rd_addr[IW-1:0];
        wr_row   = merge_row(mem[wr_idx], wdata, wmask);
        rd_fwd   = (wr_go && (waddr == rd_addr)) ? wr_row : mem[rd_idx];
        mem_we   = (state == CLEAR) || wr_go;
        mem_idx  = (state == CLEAR) ? clr_ptr : wr_idx;
        mem_wdat = (state == CLEAR) ? '0 : wr_row;
    end

    // Storage array; not reset, the clear sweep zeroes it.
    always_ff @(posedge CLK) begin
        if (mem_we) mem[mem_idx] <= mem_wdat;
    end

    // Output registers, sweep pointer and burst bookkeeping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clr_ptr   <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            strm_last <= 1'b0;
            err       <= 1'b0;
            ptr       <= '0;
            end_r     <= '0;
        end else begin
            err <= err_c;
            if (state == CLEAR) clr_ptr <= (clr_ptr == LAST_ROW) ? '0 : clr_ptr + IW'(1);
            if (state_nxt == CLEAR) begin
                rvalid    <= 1'b0;
                strm_last <= 1'b0;
            end else if (rd_go) begin
                rdata     <= rd_fwd;
                rvalid    <= 1'b1;
                strm_last <= 1'b0;
            end else if (st_go) begin
                rdata     <= rd_fwd;
                rvalid    <= 1'b1;
                strm_last <= (strm_len == ONE_W);
                ptr       <= strm_base;
                end_r     <= strm_end;
            end else if (fetch) begin
                rdata     <= rd_fwd;
                ptr       <= nxt[ADDR_WIDTH-1:0];
                strm_last <= ((nxt + ONE_W) == end_r);
            end else if (state != STREAM || xfer) begin
                rvalid    <= 1'b0;
                strm_last <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dataset_ram.sv
// Directed bench for dataset_ram: vector table for random access, hand sequences for bursts.
// Latency: outputs are sampled on the falling edge after the driving rising edge.
// Backpressure: rready pattern exercises stalls on the stream port.
module tb_dataset_ram;

    localparam int AW = 12;
    localparam int DW = 256;

    logic          CLK, RST, clr_req, we, re, strm_start, rready;
    logic [15:0]   wmask;
    logic [AW-1:0] waddr, raddr, strm_base;
    logic [AW:0]   strm_len;
    logic [DW-1:0] wdata, rdata;
    logic          rvalid, strm_last, busy, err;

    int n_chk = 0;
    int n_fail = 0;

    dataset_ram dut (
        .CLK(CLK), .RST(RST), .clr_req(clr_req), .we(we), .wmask(wmask), .waddr(waddr),
        .wdata(wdata), .re(re), .raddr(raddr), .strm_start(strm_start), .strm_base(strm_base),
        .strm_len(strm_len), .rready(rready), .rdata(rdata), .rvalid(rvalid),
        .strm_last(strm_last), .busy(busy), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic          we;
        logic [15:0]   wmask;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          re;
        logic [AW-1:0] raddr;
        logic          e_vld;
        logic          e_err;
        logic [DW-1:0] e_dat;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rowval(input int r);
        logic [DW-1:0] v;
        for (int k = 0; k < 16; k++) v[k*16 +: 16] = 16'((r << 8) | k);
        return v;
    endfunction

    function automatic logic [DW-1:0] fill(input logic [15:0] x);
        return {16{x}};
    endfunction

    function automatic vec_t mk(input logic w, input logic [15:0] m, input int wa, input logic [DW-1:0] wd,
                                input logic r, input int ra, input logic ev, input logic ee,
                                input logic [DW-1:0] ed);
        vec_t v;
        v.we = w; v.wmask = m; v.waddr = AW'(wa); v.wdata = wd;
        v.re = r; v.raddr = AW'(ra); v.e_vld = ev; v.e_err = ee; v.e_dat = ed;
        return v;
    endfunction

    task automatic idle_inputs();
        clr_req = 0; we = 0; re = 0; strm_start = 0; rready = 0;
        wmask = '0; waddr = '0; raddr = '0; strm_base = '0; strm_len = '0; wdata = '0;
    endtask

    // Counts rising edges until busy falls, bounded so a stuck DUT still ends the run.
    task automatic busy_cycles(input string nm, input int exp);
        int cnt = 0;
        do begin
            @(posedge CLK); #1;
            cnt++;
        end while (busy && cnt < 300);
        check(nm, DW'(cnt), DW'(exp));
        @(negedge CLK);
    endtask

    task automatic read_row(input string nm, input int row, input logic [DW-1:0] exp);
        re = 1; raddr = AW'(row);
        @(negedge CLK);
        re = 0;
        check({nm, "_rvalid"}, DW'(rvalid), DW'(1));
        check({nm, "_rdata"}, rdata, exp);
    endtask

    logic [DW-1:0] m8001;
    logic [DW-1:0] r7;
    logic          pat [6];
    int            b;

    initial begin
        idle_inputs();
        RST = 1;
        #1;
        check("rst_busy", DW'(busy), DW'(1));
        check("rst_rvalid", DW'(rvalid), DW'(0));
        check("rst_err", DW'(err), DW'(0));
        check("rst_rdata", rdata, '0);
        @(negedge CLK); @(negedge CLK);
        RST = 0;
        busy_cycles("sweep_cycles", 100);

        // Random-access vector table.
        for (int k = 0; k < 16; k++)
            m8001[k*16 +: 16] = (k == 0 || k == 15) ? 16'h1234 : 16'hAAAA;
        r7 = '0; r7[15:0] = 16'h0042;
        vt.push_back(mk(0, 16'h0000, 0, '0, 1, 0, 1, 0, '0));
        vt.push_back(mk(0, 16'h0000, 0, '0, 1, 57, 1, 0, '0));
        vt.push_back(mk(0, 16'h0000, 0, '0, 1, 99, 1, 0, '0));
        vt.push_back(mk(0, 16'h0000, 0, '0, 0, 0, 0, 0, '0));
        vt.push_back(mk(1, 16'hFFFF, 5, fill(16'hAAAA), 0, 0, 0, 0, '0));
        vt.push_back(mk(1, 16'h8001, 5, fill(16'h1234), 0, 0, 0, 0, '0));
        vt.push_back(mk(0, 16'h0000, 0, '0, 1, 5, 1, 0, m8001));
        vt.push_back(mk(1, 16'hFFFF, 100, fill(16'hFFFF), 0, 0, 0, 1, '0));
        vt.push_back(mk(1, 16'h0000, 99, fill(16'hFFFF), 0, 0, 0, 0, '0));
        vt.push_back(mk(0, 16'h0000, 0, '0, 1, 99, 1, 0, '0));
        vt.push_back(mk(0, 16'h0000, 0, '0, 1, 100, 0, 1, '0));
        vt.push_back(mk(1, 16'h0001, 7, fill(16'h0042), 1, 7, 1, 0, r7));
        vt.push_back(mk(0, 16'h0000, 0, '0, 1, 7, 1, 0, r7));
        for (int r = 10; r < 14; r++) vt.push_back(mk(1, 16'hFFFF, r, rowval(r), 0, 0, 0, 0, '0));
        vt.push_back(mk(0, 16'h0000, 0, '0, 1, 12, 1, 0, rowval(12)));

        foreach (vt[i]) begin
            we = vt[i].we; wmask = vt[i].wmask; waddr = vt[i].waddr; wdata = vt[i].wdata;
            re = vt[i].re; raddr = vt[i].raddr;
            @(negedge CLK);
            check($sformatf("vec%0d_rvalid", i), DW'(rvalid), DW'(vt[i].e_vld));
            check($sformatf("vec%0d_err", i), DW'(err), DW'(vt[i].e_err));
            if (vt[i].e_vld) check($sformatf("vec%0d_rdata", i), rdata, vt[i].e_dat);
        end
        idle_inputs();
        @(negedge CLK);

        // Burst of rows 10..13 with stalls and a rejected read mid-burst.
        pat = '{1, 0, 1, 1, 0, 1};
        strm_base = AW'(10); strm_len = 4; strm_start = 1;
        @(negedge CLK);
        strm_start = 0;
        b = 0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("strm%0d_rvalid", i), DW'(rvalid), DW'(1));
            check($sformatf("strm%0d_rdata", i), rdata, rowval(10 + b));
            check($sformatf("strm%0d_last", i), DW'(strm_last), DW'(b == 3));
            check($sformatf("strm%0d_err", i), DW'(err), DW'(i == 2));
            check($sformatf("strm%0d_busy", i), DW'(busy), DW'(1));
            rready = pat[i];
            re = (i == 1);
            @(negedge CLK);
            re = 0;
            if (pat[i]) b++;
        end
        rready = 0;
        check("strm_end_rvalid", DW'(rvalid), DW'(0));
        check("strm_end_busy", DW'(busy), DW'(0));
        check("strm_end_last", DW'(strm_last), DW'(0));

        // Rejected burst commands stay in IDLE.
        strm_base = AW'(98); strm_len = 3; strm_start = 1;
        @(negedge CLK);
        strm_start = 0;
        check("oor_err", DW'(err), DW'(1));
        check("oor_busy", DW'(busy), DW'(0));
        check("oor_rvalid", DW'(rvalid), DW'(0));
        strm_base = AW'(0); strm_len = 0; strm_start = 1;
        @(negedge CLK);
        strm_start = 0;
        check("len0_err", DW'(err), DW'(1));
        check("len0_busy", DW'(busy), DW'(0));

        // Clear request aborts a running burst.
        strm_base = AW'(0); strm_len = 50; strm_start = 1; rready = 1;
        @(negedge CLK);
        strm_start = 0;
        check("abort_pre_rvalid", DW'(rvalid), DW'(1));
        @(negedge CLK); @(negedge CLK);
        clr_req = 1;
        @(negedge CLK);
        clr_req = 0; rready = 0;
        check("abort_rvalid", DW'(rvalid), DW'(0));
        check("abort_busy", DW'(busy), DW'(1));
        busy_cycles("abort_sweep_cycles", 100);
        read_row("clr5", 5, '0);
        read_row("clr7", 7, '0);
        read_row("clr13", 13, '0);

        // Asynchronous reset mid-burst.
        we = 1; wmask = 16'hFFFF; waddr = AW'(0); wdata = rowval(3);
        @(negedge CLK);
        we = 0;
        strm_base = AW'(0); strm_len = 20; strm_start = 1;
        @(negedge CLK);
        strm_start = 0;
        check("arst_pre_rvalid", DW'(rvalid), DW'(1));
        check("arst_pre_rdata", rdata, rowval(3));
        #2 RST = 1;
        #1;
        check("arst_rvalid", DW'(rvalid), DW'(0));
        check("arst_rdata", rdata, '0);
        check("arst_busy", DW'(busy), DW'(1));
        @(negedge CLK);
        RST = 0;
        busy_cycles("arst_sweep_cycles", 100);
        read_row("arst_row0", 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
